// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops (add/sub/eq/and/or/slt) finish the clock after accept.
// MUL is an iterative shift-add that always runs WIDTH iterations.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] r,
  input  logic             alusrc,
  input  logic [OPW-1:0]   alucontrol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [OPW-1:0] OP_SUB = OPW'(0);
  localparam logic [OPW-1:0] OP_ADD = OPW'(1);
  localparam logic [OPW-1:0] OP_EQ  = OPW'(2);
  localparam logic [OPW-1:0] OP_AND = OPW'(3);
  localparam logic [OPW-1:0] OP_OR  = OPW'(4);
  localparam logic [OPW-1:0] OP_SLT = OPW'(5);
  localparam logic [OPW-1:0] OP_MUL = OPW'(6);

  typedef enum logic [1:0] {IDLE, MULS, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] c;
    logic             zero;
    logic             ovf;
    logic             illegal;
  } res_t;

  state_t           state;
  res_t             res, out_q;
  logic [WIDTH-1:0] bsel, sum, diff;
  logic [WIDTH-1:0] ma, mb, acc, acc_nxt;
  logic [CW-1:0]    cnt;

  assign bsel    = alusrc ? r : b;
  assign sum     = a + bsel;
  assign diff    = a - bsel;
  // one shift-add step: multiplicand shifts up, multiplier shifts down
  assign acc_nxt = acc + (mb[0] ? ma : '0);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign c         = out_q.c;
  assign zero      = out_q.zero;
  assign ovf       = out_q.ovf;
  assign illegal   = out_q.illegal;

  // single-cycle result for everything except MUL (handled iteratively)
  always_comb begin
    res = '0;
    case (alucontrol)
      OP_SUB: begin
        res.c   = diff;
        res.ovf = (a[WIDTH-1] != bsel[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ADD: begin
        res.c   = sum;
        res.ovf = (a[WIDTH-1] == bsel[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_EQ:  res.c = '0;
      OP_AND: res.c = a & bsel;
      OP_OR:  res.c = a | bsel;
      OP_SLT: res.c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(bsel))};
      OP_MUL: res.c = '0;
      default: res.illegal = 1'b1;
    endcase
    if (alucontrol == OP_EQ) res.zero = (a == bsel);
    else                     res.zero = !res.illegal && (res.c == '0);
  end

  // control FSM, multiplier datapath and held result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      out_q <= '0;
      ma    <= '0;
      mb    <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (alucontrol == OP_MUL) begin
            ma    <= a;
            mb    <= bsel;
            acc   <= '0;
            cnt   <= '0;
            state <= MULS;
          end else begin
            out_q <= res;
            state <= DONE;
          end
        end
        MULS: begin
          acc <= acc_nxt;
          ma  <= ma << 1;
          mb  <= mb >> 1;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) begin
            out_q.c       <= acc_nxt;
            out_q.zero    <= (acc_nxt == '0);
            out_q.ovf     <= 1'b0;
            out_q.illegal <= 1'b0;
            state         <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: one 32-bit and one 8-bit instance share operand buses,
// each with its own in_valid. Expected results are pushed to a scoreboard at
// accept and popped when the selected instance presents out_valid.
module tb_alu_mc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] a, b, r;
  logic        alusrc;
  logic [2:0]  op;
  logic        out_ready;
  logic        iv32, iv8;

  logic        rdy32, ov32, z32, o32, il32;
  logic [31:0] c32;
  logic        rdy8, ov8, z8, o8, il8;
  logic [7:0]  c8;

  alu_mc #(.WIDTH(32), .OPW(3)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(rdy32),
    .a(a), .b(b), .r(r), .alusrc(alusrc), .alucontrol(op),
    .out_valid(ov32), .out_ready(out_ready),
    .c(c32), .zero(z32), .ovf(o32), .illegal(il32));

  alu_mc #(.WIDTH(8), .OPW(3)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8),
    .a(a[7:0]), .b(b[7:0]), .r(r[7:0]), .alusrc(alusrc), .alucontrol(op),
    .out_valid(ov8), .out_ready(out_ready),
    .c(c8), .zero(z8), .ovf(o8), .illegal(il8));

  // view of whichever instance is under test
  logic        use8;
  logic        s_rdy, s_ov, s_z, s_o, s_il;
  logic [31:0] s_c;
  always_comb begin
    s_rdy = use8 ? rdy8 : rdy32;
    s_ov  = use8 ? ov8  : ov32;
    s_z   = use8 ? z8   : z32;
    s_o   = use8 ? o8   : o32;
    s_il  = use8 ? il8  : il32;
    s_c   = use8 ? {24'b0, c8} : c32;
  end

  typedef struct {
    logic [31:0] c;
    logic        z, o, il;
    int          lat;
  } exp_t;

  exp_t q[$];
  int npass = 0, nfail = 0, ntot = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model, width w in {8,32}
  function automatic exp_t model(input logic [2:0] o, input logic [31:0] aa_i,
                                 input logic [31:0] bb_i, input int w);
    exp_t e;
    logic [31:0] m, aa, bb;
    logic [63:0] p;
    int s;
    s  = w - 1;
    m  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    aa = aa_i & m;
    bb = bb_i & m;
    e.c = 0; e.z = 0; e.o = 0; e.il = 0;
    e.lat = (o == 3'd6) ? w + 1 : 1;
    case (o)
      3'd0: begin e.c = (aa - bb) & m; e.o = (aa[s] != bb[s]) && (e.c[s] != aa[s]); end
      3'd1: begin e.c = (aa + bb) & m; e.o = (aa[s] == bb[s]) && (e.c[s] != aa[s]); end
      3'd2: e.c = 0;
      3'd3: e.c = aa & bb;
      3'd4: e.c = aa | bb;
      3'd5: e.c = (aa[s] != bb[s]) ? {31'b0, aa[s]} : {31'b0, (aa < bb)};
      3'd6: begin p = {32'b0, aa} * {32'b0, bb}; e.c = p[31:0] & m; end
      default: e.il = 1;
    endcase
    if (o == 3'd2)      e.z = (aa == bb);
    else if (o == 3'd7) e.z = 0;
    else                e.z = (e.c == 0);
    return e;
  endfunction

  // wait for in_ready, present one operand set, scramble inputs after accept
  task automatic issue(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [31:0] rr, input logic src);
    int n = 0;
    @(negedge clk);
    while (!s_rdy && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("in_ready_wait", 32'(s_rdy), 32'd1);
    op = o; a = aa; b = bb; r = rr; alusrc = src;
    if (use8) iv8 = 1'b1; else iv32 = 1'b1;
    q.push_back(model(o, aa, src ? rr : bb, use8 ? 8 : 32));
    @(posedge clk); #1;
    iv8 = 1'b0; iv32 = 1'b0;
    a = $urandom; b = $urandom; r = $urandom; alusrc = 1'($urandom); op = 3'($urandom);
  endtask

  // wait for the result, optionally stall it, then compare and release
  task automatic collect(input int stall, input bit pulse);
    int lat = 1;
    bit rdy_low = 1, stable = 1;
    exp_t e;
    logic [31:0] c0;
    logic z0, o0, il0;
    @(negedge clk);
    while (!s_ov && lat < 100) begin
      if (s_rdy) rdy_low = 0;
      if (pulse) begin if (use8) iv8 = 1'($urandom); else iv32 = 1'($urandom); end
      @(negedge clk);
      lat++;
    end
    iv8 = 1'b0; iv32 = 1'b0;
    if (q.size() == 0) begin
      chk("sb_nonempty", 32'(q.size()), 32'd1);
      return;
    end
    e = q.pop_front();
    chk("latency", 32'(lat), 32'(e.lat));
    if (e.lat > 1) chk("busy_in_ready_low", 32'(rdy_low), 32'd1);
    c0 = s_c; z0 = s_z; o0 = s_o; il0 = s_il;
    repeat (stall) begin
      @(negedge clk);
      if (s_c !== c0 || s_z !== z0 || s_o !== o0 || s_il !== il0 || s_rdy || !s_ov)
        stable = 0;
    end
    if (stall > 0) chk("hold_stable", 32'(stable), 32'd1);
    chk("c", s_c, e.c);
    chk("zero", 32'(s_z), 32'(e.z));
    chk("ovf", 32'(s_o), 32'(e.o));
    chk("illegal", 32'(s_il), 32'(e.il));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("released_rdy_ov", {30'b0, s_rdy, s_ov}, 32'b10);
  endtask

  initial begin
    rst = 1'b1; a = 0; b = 0; r = 0; alusrc = 0; op = 0;
    out_ready = 0; iv32 = 0; iv8 = 0; use8 = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      use8 = k[0];
      #1;
      chk("rst_in_ready", 32'(s_rdy), 32'd1);
      chk("rst_out_valid", 32'(s_ov), 32'd0);
      chk("rst_c", s_c, 32'd0);
      chk("rst_flags", {29'b0, s_z, s_o, s_il}, 32'd0);
    end
    use8 = 0;
    @(negedge clk); rst = 1'b0;

    // directed, 32-bit
    issue(3'd1, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0); collect(0, 0);
    chk("add_ovf_c", s_c, 32'h8000_0000);
    issue(3'd0, 32'h5, 32'h9, 32'h5, 1'b1);         collect(0, 0);
    issue(3'd2, 32'h3, 32'h4, 32'h0, 1'b0);         collect(0, 0);
    issue(3'd6, 32'h0000_FFFF, 32'h0001_0001, 32'h0, 1'b0); collect(0, 1);
    chk("mul_c", s_c, 32'hFFFF_FFFF);
    issue(3'd6, 32'h5, 32'h0, 32'h0, 1'b0);         collect(0, 0);
    issue(3'd7, 32'h1234, 32'h5678, 32'h0, 1'b0);   collect(5, 0);
    issue(3'd5, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0); collect(0, 0);

    // reset in the middle of a multiply
    issue(3'd6, 32'h1234_5678, 32'h9ABC_DEF1, 32'h0, 1'b0);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midmul_rst_out_valid", 32'(s_ov), 32'd0);
    chk("midmul_rst_in_ready", 32'(s_rdy), 32'd1);
    chk("midmul_rst_c", s_c, 32'd0);
    void'(q.pop_back());
    @(posedge clk); #2 rst = 1'b0;
    issue(3'd1, 32'd2, 32'd3, 32'h0, 1'b0); collect(0, 0);
    chk("post_rst_add", s_c, 32'd5);

    // random back-to-back, both widths
    for (int k = 0; k < 2; k++) begin
      use8 = k[0];
      repeat (40) begin
        logic [31:0] ra, rb, rr;
        ra = $urandom; rb = $urandom; rr = $urandom;
        case ($urandom_range(0, 5))
          0: ra = 32'h7FFF_FFFF;
          1: rb = 32'h8000_0000;
          2: rb = ra;
          3: begin ra = 32'h7F; rb = 32'h1; end
          default: ;
        endcase
        issue(3'($urandom_range(0, 7)), ra, rb, rr, 1'($urandom));
        collect($urandom_range(0, 3), 1'($urandom));
      end
    end
    chk("sb_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
